// File: rtl/timer_pkg.sv
// timer_pkg: shared widths and status-bit positions for the timer block.
package timer_pkg;
  localparam int TIMER_CNT_W = 8;
  localparam int TSR_OVF_BIT = 0;
  localparam int TSR_UDF_BIT = 1;
  localparam int TSR_CMP_BIT = 2;
  localparam int TSR_W = 3;
endpackage

// File: rtl/timer_flag_w1c.sv
// timer_flag_w1c: one sticky status flag, write-1-to-clear, set beats clear.
module timer_flag_w1c (
  input  logic pclk,
  input  logic preset_n,
  input  logic set,
  input  logic clr,
  output logic flag
);
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) flag <= 1'b0;
    else flag <= set | (flag & ~clr);
endmodule

// File: rtl/timer_status.sv
// timer_status: wrap detection, sticky W1C status flags and irq gating.
// Optional compare-match flag enabled by defining TIMER_CMP_MATCH_EN.
module timer_status
  import timer_pkg::*;
#(
  parameter int CNT_W = TIMER_CNT_W
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             en,
  input  logic             load,
  input  logic             count_enable,
  input  logic             updown,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] last_cnt,
  input  logic [CNT_W-1:0] tcmp,
  input  logic [TSR_W-1:0] tier,
  input  logic             tsr_wr,
  input  logic [TSR_W-1:0] tsr_wdata,
  output logic [TSR_W-1:0] tsr,
  output logic             irq_ovf,
  output logic             irq_udf,
  output logic             irq_cmp,
  output logic             irq
);
  logic step_d, dir_d;
  logic [TSR_W-1:0] det, clr;
  // Latched with the counter update so detection sees the step that produced cnt.
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      step_d <= 1'b0;
      dir_d  <= 1'b0;
    end else begin
      step_d <= en & count_enable & ~load;
      dir_d  <= updown;
    end
  assign det[TSR_OVF_BIT] = step_d & ~dir_d & (&last_cnt) & ~(|cnt);
  assign det[TSR_UDF_BIT] = step_d & dir_d & ~(|last_cnt) & (&cnt);
  assign clr = {TSR_W{tsr_wr}} & tsr_wdata;
  for (genvar i = 0; i < 2; i++) begin : g_flag
    timer_flag_w1c u_flag (.pclk(pclk), .preset_n(preset_n), .set(det[i]), .clr(clr[i]), .flag(tsr[i]));
  end
`ifdef TIMER_CMP_MATCH_EN
  assign det[TSR_CMP_BIT] = step_d & (cnt == tcmp);
  timer_flag_w1c u_cmp (.pclk(pclk), .preset_n(preset_n), .set(det[TSR_CMP_BIT]), .clr(clr[TSR_CMP_BIT]), .flag(tsr[TSR_CMP_BIT]));
`else
  logic unused_ok;
  assign det[TSR_CMP_BIT] = 1'b0;
  assign tsr[TSR_CMP_BIT] = 1'b0;
  assign unused_ok = ^{tcmp, clr[TSR_CMP_BIT], det[TSR_CMP_BIT]};
`endif
  assign irq_ovf = tsr[TSR_OVF_BIT] & tier[TSR_OVF_BIT];
  assign irq_udf = tsr[TSR_UDF_BIT] & tier[TSR_UDF_BIT];
  assign irq_cmp = tsr[TSR_CMP_BIT] & tier[TSR_CMP_BIT];
  assign irq = irq_ovf | irq_udf | irq_cmp;
endmodule
